// File: rtl/img_row_packer.sv
// rtl/img_row_packer.sv - packs IN_W-bit pixel words into 640-bit rows and writes them to a row buffer.
// Optional IMG_PACK_BSWAP_EN: byte-reverse each accepted word before storing it.
module img_row_packer #(
   parameter int IN_W = 32,
   parameter int ROWS = 512
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            in_valid,
   input  logic [IN_W-1:0] in_data,
   output logic            in_ready,
   output logic            buf_we,
   output logic [8:0]      buf_waddr,
   output logic [639:0]    buf_wdata,
   output logic            busy,
   output logic            frame_done
);
   localparam int WORDS = 640 / IN_W;
   localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
   localparam logic [8:0]    LAST_ROW  = 9'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   word_q, word_d;
   logic [8:0]      row_q, row_d;
   logic [639:0]    row_reg_q, row_reg_d;
   logic [IN_W-1:0] word_in;

`ifdef IMG_PACK_BSWAP_EN
   always_comb begin
      word_in = '0;
      for (int b = 0; b < IN_W / 8; b++) begin
         word_in[IN_W-1-8*b -: 8] = in_data[8*b +: 8];
      end
   end
`else
   assign word_in = in_data;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         word_q    <= '0;
         row_q     <= '0;
         row_reg_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         row_q     <= row_d;
         row_reg_q <= row_reg_d;
      end
   end

   // Handshake and write strobe depend on state only, never on in_valid.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      row_d      = row_q;
      row_reg_d  = row_reg_q;
      in_ready   = 1'b0;
      buf_we     = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILL;
               word_d  = '0;
               row_d   = '0;
            end
         end
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               row_reg_d[int'(word_q) * IN_W +: IN_W] = word_in;
               if (word_q == LAST_WORD) begin
                  state_d = S_WRITE;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            buf_we = 1'b1;
            if (row_q == LAST_ROW) begin
               state_d = S_DONE;
            end else begin
               row_d   = row_q + 1'b1;
               word_d  = '0;
               state_d = S_FILL;
            end
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign buf_waddr = row_q;
   assign buf_wdata = row_reg_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_img_row_packer.sv
// tb/tb_img_row_packer.sv - directed/random bench for img_row_packer against a word-queue row model.
// Honours IMG_PACK_BSWAP_EN when the design is built with it.
module tb_img_row_packer;
   logic        clk = 1'b0;
   logic        rst_n, start, start1, in_valid;
   logic [31:0] in_data;

   logic         rdy, we, busy, done;
   logic [8:0]   waddr;
   logic [639:0] wdata;
   logic         rdy1, we1, busy1, done1;
   logic [8:0]   waddr1;
   logic [639:0] wdata1;

   img_row_packer #(.IN_W(32), .ROWS(512)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy), .buf_we(we), .buf_waddr(waddr), .buf_wdata(wdata),
      .busy(busy), .frame_done(done));

   img_row_packer #(.IN_W(32), .ROWS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .buf_we(we1), .buf_waddr(waddr1), .buf_wdata(wdata1),
      .busy(busy1), .frame_done(done1));

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]   a;
      logic [639:0] d;
      int           c;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] sent[$];
   int cyc = 0, first_acc = -1, done_cnt = 0, done_cyc = -1, rdy_in_we = 0;
   int errors = 0, checks = 0, tmo = 0;
   bit mon_clr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         wq.delete();
         first_acc = -1; done_cnt = 0; done_cyc = -1; rdy_in_we = 0;
      end else begin
         if (we) wq.push_back('{waddr, wdata, cyc});
         if (we && rdy) rdy_in_we++;
         if (in_valid && rdy && first_acc < 0) first_acc = cyc;
         if (done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef IMG_PACK_BSWAP_EN
      return {<<8{w}};
`else
      return w;
`endif
   endfunction

   // Row r of the current frame is the 20 words sent for it, word 0 lowest.
   function automatic logic [639:0] exp_row(input int r);
      logic [639:0] v = '0;
      for (int k = 0; k < 20; k++) v = v | (640'(stored(sent[20*r+k])) << (32*k));
      return v;
   endfunction

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic push(input logic [31:0] w, input bit on1, input bit stall);
      int g = 0;
      if (stall) begin
         while ($urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!(on1 ? rdy1 : rdy)) begin
         g++;
         if (g > 64) begin
            tmo++;
            $error("FAIL push_timeout observed=ready_low expected=ready_high");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      int g = 0;
      while (wq.size() < n && g < 100) begin @(negedge clk); g++; end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] w;
      rst_n = 1'b0; start = 1'b1; start1 = 1'b1; in_valid = 1'b1; in_data = 32'hdead_beef;

      // Reset held with start/in_valid asserted
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         chk("rst_ctrl", 640'({rdy, we, waddr, busy, done}), 640'(0));
         chk("rst_wdata", wdata, 640'(0));
         chk("rst_ctrl1", 640'({rdy1, we1, waddr1, busy1, done1}), 640'(0));
      end
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0; start1 = 1'b0; in_valid = 1'b0;
      clear_mon();

      // Single-row frame on the ROWS=1 instance
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      chk("r1_ready_after_start", 640'(rdy1), 640'(1));
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) push(32'(k), 1'b1, 1'b0);
      @(negedge clk);
      chk("r1_we", 640'(we1), 640'(1));
      chk("r1_waddr", 640'(waddr1), 640'(0));
      chk("r1_slot0", 640'(wdata1[31:0]), 640'(stored(32'h0)));
      chk("r1_slot19", 640'(wdata1[639:608]), 640'(stored(32'h13)));
      chk("r1_ready_in_write", 640'(rdy1), 640'(0));
      @(negedge clk);
      chk("r1_done", 640'({done1, we1, busy1}), 640'(3'b101));
      @(negedge clk);
      chk("r1_idle", 640'({done1, busy1}), 640'(0));
      chk("r1_big_dut_untouched", 640'(wq.size()), 640'(0));
      @(posedge clk); #1;

      // Full frame, back-to-back, word = {row, word}
      clear_mon();
      sent.delete();
      pulse_start();
      for (int r = 0; r < 512; r++) begin
         for (int k = 0; k < 20; k++) begin
            w = {16'(r), 16'(k)};
            sent.push_back(w);
            push(w, 1'b0, 1'b0);
         end
      end
      begin
         int g = 0;
         while (done_cnt == 0 && g < 10) begin @(negedge clk); g++; end
      end
      @(negedge clk);
      chk("ff_writes", 640'(wq.size()), 640'(512));
      for (int r = 0; r < 512 && r < wq.size(); r++) begin
         chk($sformatf("ff_addr_%0d", r), 640'(wq[r].a), 640'(r));
         chk($sformatf("ff_data_%0d", r), wq[r].d, exp_row(r));
      end
      if (wq.size() > 0) begin
         chk("ff_cycles", 640'(wq[wq.size()-1].c - first_acc + 1), 640'(10752));
         chk("ff_done_latency", 640'(done_cyc), 640'(wq[wq.size()-1].c + 1));
      end
      chk("ff_done_count", 640'(done_cnt), 640'(1));
      chk("ff_ready_in_write", 640'(rdy_in_we), 640'(0));
      chk("ff_busy_after", 640'(busy), 640'(0));
      @(posedge clk); #1;

      // Random data with ~50% valid gaps; start held high while busy
      clear_mon();
      sent.delete();
      pulse_start();
      start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         w = $urandom;
         sent.push_back(w);
         push(w, 1'b0, 1'b1);
      end
      wait_writes(3);
      start = 1'b0;
      chk("st_writes", 640'(wq.size()), 640'(3));
      for (int r = 0; r < 3 && r < wq.size(); r++) begin
         chk($sformatf("st_addr_%0d", r), 640'(wq[r].a), 640'(r));
         chk($sformatf("st_data_%0d", r), wq[r].d, exp_row(r));
      end
      chk("st_ready_in_write", 640'(rdy_in_we), 640'(0));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset after 7 words of row 3, then restart
      clear_mon();
      sent.delete();
      pulse_start();
      for (int i = 0; i < 67; i++) begin
         w = $urandom;
         sent.push_back(w);
         push(w, 1'b0, 1'b0);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_ctrl_after_rst", 640'({rdy, we, waddr, busy, done}), 640'(0));
      chk("mr_wdata_after_rst", wdata, 640'(0));
      repeat (4) @(negedge clk);
      chk("mr_writes_before_restart", 640'(wq.size()), 640'(3));
      if (wq.size() > 0) chk("mr_last_addr", 640'(wq[wq.size()-1].a), 640'(2));
      @(posedge clk); #1;
      clear_mon();
      sent.delete();
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         w = (i == 0) ? 32'h1122_3344 : $urandom;
         sent.push_back(w);
         push(w, 1'b0, 1'b0);
      end
      wait_writes(1);
      chk("mr_restart_writes", 640'(wq.size()), 640'(1));
      if (wq.size() > 0) begin
         chk("mr_restart_addr", 640'(wq[0].a), 640'(0));
`ifdef IMG_PACK_BSWAP_EN
         chk("mr_slot0_order", 640'(wq[0].d[31:0]), 640'(32'h4433_2211));
`else
         chk("mr_slot0_order", 640'(wq[0].d[31:0]), 640'(32'h1122_3344));
`endif
         chk("mr_restart_row", wq[0].d, exp_row(0));
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      chk("no_timeouts", 640'(tmo), 640'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/img_row_packer.md
# img_row_packer

Upstream write-side stage for the coprocessor's 512-row × 640-bit image line buffer. Accepts a stream of 32-bit pixel words over a valid/ready handshake, assembles 20 consecutive words into one 640-bit row, and issues a single-cycle write (we/waddr/wdata) to the buffer at an auto-incrementing row address. A frame is exactly ROWS rows; completion is signalled with a one-cycle pulse.

## Interface
- IN_W, 32, input word width; must divide 640 exactly.
- ROWS, 512, rows per frame; row address width is 9 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a frame; sampled only in IDLE.
- in_valid  input  1  in_data holds a valid word.
- in_data  input  IN_W  pixel word.
- in_ready  output  1  packer accepts a word this cycle.
- buf_we  output  1  row write strobe to the buffer.
- buf_waddr  output  9  row address of the write.
- buf_wdata  output  640  assembled row.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse after the last row write.

## Operation
- WORDS = 640/IN_W (20 by default); word counter 0..WORDS-1, row counter 0..ROWS-1.
- States: IDLE, FILL, WRITE, DONE.
- IDLE: in_ready=0. start=1 → FILL, clears word and row counters.
- FILL: in_ready=1. Transfer occurs when in_valid && in_ready; word k is stored at row_reg[k*IN_W +: IN_W] (word 0 at LSB). Transfer of word WORDS-1 → WRITE. in_valid low stalls; nothing is lost or duplicated.
- WRITE: in_ready=0; buf_we=1, buf_waddr=row counter, buf_wdata=row_reg for exactly one cycle. If row counter = ROWS-1 → DONE, else row counter+1, word counter=0 → FILL.
- DONE: frame_done=1 for one cycle → IDLE.
- start while busy is ignored (no restart, no abort).
- buf_wdata is valid only while buf_we=1; it holds row_reg otherwise.
- Row counter never wraps mid-frame; each frame writes rows 0..ROWS-1 in order exactly once.

## Timing
- Reset values: in_ready=0, buf_we=0, buf_waddr=0, buf_wdata=0, busy=0, frame_done=0; state IDLE, counters and row_reg cleared.
- start at cycle t → in_ready=1 at t+1.
- Last word of a row accepted at cycle t → buf_we=1 at t+1 → in_ready=1 again at t+2.
- Minimum cost per row with in_valid held high: WORDS+1 cycles (21 by default); full frame: ROWS×(WORDS+1) cycles from first accept to last write (10752 by default), frame_done one cycle after the last write.
- Reset asserted mid-frame: next cycle is IDLE with all outputs at reset values; the partial row is discarded and never written; an in-flight WRITE cycle coinciding with rst_n=0 still presents buf_we=1 that cycle (buffer sees it), but no further writes occur.
- in_ready is a function of state only; it does not depend on in_valid.

## Configuration
- IMG_PACK_BSWAP_EN defined: each accepted word is byte-reversed before storage (in_data[7:0] lands in the word slot's [IN_W-1 -: 8]), supporting little-endian DMA sources. Requires IN_W to be a multiple of 8.
- Undefined: words are stored unmodified. All timing is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1, in_valid=1 → all outputs 0, no buf_we.
- Single row, ROWS=1: start, then words 0x00000000..0x00000013 back-to-back → one buf_we at waddr 0, wdata[31:0]=0x0, wdata[639:608]=0x13, frame_done pulses the next cycle, busy drops after it.
- Full frame, ROWS=512, word value = {row[15:0], word[15:0]} → 512 writes, waddr 0..511 ascending, each slot matches, 10752 cycles from first accept to last write, exactly one frame_done.
- Stalls: random in_valid gaps (≈50%) over 3 rows → identical buffer contents to the no-stall run; in_ready=0 during every WRITE cycle.
- Reset mid-row: after 7 words of row 3 pull rst_n low for 1 cycle, then restart → no write to address 3 before restart; new frame begins at waddr 0.
- IMG_PACK_BSWAP_EN build: word 0x11223344 in slot 0 → wdata[31:0]=0x44332211; without the macro, 0x11223344.
